// File: rtl/exc_arbiter_pkg.sv
// Shared definitions for the exception/interrupt arbiter.
//   - ExcCode constants written into the cause unit
//   - exc_req bit positions (bit 0 = highest priority)
//   - arbiter FSM state encoding
//   - priority encoder from exc_req to ExcCode
`ifndef EXC_ARBITER_DEFS
`define EXC_ARBITER_DEFS
`define ZERO   1'b0
`define UNKNOW 1'bx
`endif

package exc_arbiter_pkg;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    // exc_req bit assignments, listed highest priority first
    localparam int EXC_BIT_ADEL_IF = 0;
    localparam int EXC_BIT_RI      = 1;
    localparam int EXC_BIT_OV      = 2;
    localparam int EXC_BIT_SYS     = 3;
    localparam int EXC_BIT_BP      = 4;
    localparam int EXC_BIT_ADEL_LD = 5;
    localparam int EXC_BIT_ADES    = 6;
    localparam int EXC_BIT_TR      = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ABORT   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_HANDLER = 2'd3
    } arb_state_e;

    // Lowest set bit wins. Returns EXC_INT when nothing is requested.
    function automatic logic [4:0] exc_code_of(input logic [7:0] req);
        logic [4:0] code;
        code = EXC_INT;
        if      (req[EXC_BIT_ADEL_IF]) code = EXC_ADEL;
        else if (req[EXC_BIT_RI])      code = EXC_RI;
        else if (req[EXC_BIT_OV])      code = EXC_OV;
        else if (req[EXC_BIT_SYS])     code = EXC_SYS;
        else if (req[EXC_BIT_BP])      code = EXC_BP;
        else if (req[EXC_BIT_ADEL_LD]) code = EXC_ADEL;
        else if (req[EXC_BIT_ADES])    code = EXC_ADES;
        else if (req[EXC_BIT_TR])      code = EXC_TR;
        return code;
    endfunction

endpackage

// File: rtl/exc_arbiter_int_sync.sv
// Register primitives and the hardware-interrupt synchroniser.
//   flopr    : WIDTH-bit register, synchronous active-low reset to zero
//              ports: clk, rst, d_i, q_o
//   flopren  : flopr with load enable
//              ports: clk, rst, en_i, d_i, q_o
//   int_sync : SYNC_STAGES-deep chain of flopr on a WIDTH-bit async bus
//              ports: clk, rst, d_i (async), q_o (synchronised)

module flopr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk) begin
        if (!rst) q_o <= '0;
        else      q_o <= d_i;
    end
endmodule

module flopren #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk) begin
        if (!rst)      q_o <= '0;
        else if (en_i) q_o <= d_i;
    end
endmodule

module int_sync #(
    parameter int SYNC_STAGES = 2,   // 2 or 3
    parameter int WIDTH       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            flopr #(.WIDTH(WIDTH)) u_ff (
                .clk (clk),
                .rst (rst),
                .d_i (d_i),
                .q_o (stage_q[0])
            );
        end else begin : g_next
            flopr #(.WIDTH(WIDTH)) u_ff (
                .clk (clk),
                .rst (rst),
                .d_i (stage_q[g-1]),
                .q_o (stage_q[g])
            );
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];
endmodule

// File: rtl/exc_arbiter.sv
// Exception / interrupt arbiter feeding the cause unit.
// Picks one event per sequence (synchronous exception beats interrupt),
// pulses exception_abort or irq_h/irq_s for one cycle, requests a pipeline
// flush and then waits in HANDLER until ERET retires.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   exc_req[7:0]      exception requests, bit 0 highest priority
//   in_delay_slot     faulting instruction is in a delay slot
//   hw_int[5:0]       raw async interrupt lines (synchronised here)
//   sw_int[1:0]       software interrupt bits
//   int_mask[7:0]     IM[7:2] masks hw_int, IM[1:0] masks sw_int
//   int_enable        global interrupt enable
//   flush_ack         pipeline flush complete
//   eret              ERET retired
//   exception_abort   pulse: exception taken
//   exception_code    ExcCode of the taken event (held)
//   bd_p              delay-slot flag of the taken event (held)
//   irq_h, irq_s      pulses: hardware / software interrupt taken
//   ip_h, ip_s        pending masked interrupt snapshot (held)
//   flush_req         flush request level
//   busy              not IDLE
//
// state   | meaning
// IDLE    | sampling exc_req and eligible interrupts
// ABORT   | one cycle; event outputs valid, pulses high
// FLUSH   | flush_req held until flush_ack
// HANDLER | handler running, waiting for eret
module exc_arbiter
    import exc_arbiter_pkg::*;
#(
    parameter int N_HW_INT    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          exc_req,
    input  logic                in_delay_slot,
    input  logic [N_HW_INT-1:0] hw_int,
    input  logic [1:0]          sw_int,
    input  logic [7:0]          int_mask,
    input  logic                int_enable,
    input  logic                flush_ack,
    input  logic                eret,
    output logic                exception_abort,
    output logic [4:0]          exception_code,
    output logic                bd_p,
    output logic                irq_h,
    output logic                irq_s,
    output logic [N_HW_INT-1:0] ip_h,
    output logic [1:0]          ip_s,
    output logic                flush_req,
    output logic                busy
);

    logic [N_HW_INT-1:0] sync_hw;
    logic [N_HW_INT-1:0] pend_h;
    logic [1:0]          pend_s;
    logic                exc_any;
    logic                int_elig;
    logic                armed_q;
    logic                take;
    logic                take_exc;
    logic                take_int;
    logic [1:0]          state_bits_q;
    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [4:0]          code_d;

    int_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (N_HW_INT)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d_i (hw_int),
        .q_o (sync_hw)
    );

    assign pend_h   = sync_hw & int_mask[7:2];
    assign pend_s   = sw_int  & int_mask[1:0];
    assign exc_any  = |exc_req;
    assign int_elig = int_enable & ((|pend_h) | (|pend_s));

    // Low for the first edge after reset release so nothing is taken then.
    flopr #(.WIDTH(1)) u_armed (
        .clk (clk),
        .rst (rst),
        .d_i (1'b1),
        .q_o (armed_q)
    );

    // An exception in the same cycle as an interrupt wins; the level
    // interrupt is simply seen again once the FSM is back in IDLE.
    assign take     = (state_q == ST_IDLE) & armed_q & (exc_any | int_elig);
    assign take_exc = take & exc_any;
    assign take_int = take & ~exc_any;

    // State register
    flopr #(.WIDTH(2)) u_state (
        .clk (clk),
        .rst (rst),
        .d_i (state_d),
        .q_o (state_bits_q)
    );
    assign state_q = arb_state_e'(state_bits_q);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (take)      state_d = ST_ABORT;
            ST_ABORT:                  state_d = ST_FLUSH;
            ST_FLUSH:   if (flush_ack) state_d = ST_HANDLER;
            ST_HANDLER: if (eret)      state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state_q != ST_IDLE);
        flush_req = (state_q == ST_ABORT) | (state_q == ST_FLUSH);
    end

    // Event outputs, registered on the IDLE->ABORT edge
    assign code_d = take_exc ? exc_code_of(exc_req) : EXC_INT;

    flopr #(.WIDTH(1)) u_abort (
        .clk (clk), .rst (rst), .d_i (take_exc), .q_o (exception_abort)
    );
    flopr #(.WIDTH(1)) u_irq_h (
        .clk (clk), .rst (rst), .d_i (take_int & (|pend_h)), .q_o (irq_h)
    );
    flopr #(.WIDTH(1)) u_irq_s (
        .clk (clk), .rst (rst), .d_i (take_int & (|pend_s)), .q_o (irq_s)
    );
    flopren #(.WIDTH(5)) u_code (
        .clk (clk), .rst (rst), .en_i (take), .d_i (code_d), .q_o (exception_code)
    );
    flopren #(.WIDTH(1)) u_bd (
        .clk (clk), .rst (rst), .en_i (take), .d_i (in_delay_slot), .q_o (bd_p)
    );
    flopren #(.WIDTH(N_HW_INT)) u_ip_h (
        .clk (clk), .rst (rst), .en_i (take), .d_i (pend_h), .q_o (ip_h)
    );
    flopren #(.WIDTH(2)) u_ip_s (
        .clk (clk), .rst (rst), .en_i (take), .d_i (pend_s), .q_o (ip_s)
    );

endmodule

// File: tb/tb_exc_arbiter.sv
module tb_exc_arbiter;

    localparam int SYNC = 2;
    localparam int CODES [8] = '{4, 10, 12, 8, 9, 4, 5, 13};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] exc_req;
    logic       in_delay_slot;
    logic [5:0] hw_int;
    logic [1:0] sw_int;
    logic [7:0] int_mask;
    logic       int_enable;
    logic       flush_ack;
    logic       eret;
    logic       exception_abort;
    logic [4:0] exception_code;
    logic       bd_p;
    logic       irq_h;
    logic       irq_s;
    logic [5:0] ip_h;
    logic [1:0] ip_s;
    logic       flush_req;
    logic       busy;

    exc_arbiter #(.N_HW_INT(6), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .rst             (rst),
        .exc_req         (exc_req),
        .in_delay_slot   (in_delay_slot),
        .hw_int          (hw_int),
        .sw_int          (sw_int),
        .int_mask        (int_mask),
        .int_enable      (int_enable),
        .flush_ack       (flush_ack),
        .eret            (eret),
        .exception_abort (exception_abort),
        .exception_code  (exception_code),
        .bd_p            (bd_p),
        .irq_h           (irq_h),
        .irq_s           (irq_s),
        .ip_h            (ip_h),
        .ip_s            (ip_s),
        .flush_req       (flush_req),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: where the arbiter is in its take/flush/handler
    // sequence, the interrupt lines as they look after the synchroniser
    // delay, and the values the cause unit should currently be seeing.
    typedef enum {P_IDLE, P_ABORT, P_FLUSH, P_HANDLER} phase_e;
    phase_e     m_ph    = P_IDLE;
    bit         m_armed = 0;
    logic [5:0] m_hist [$];          // hw_int samples, newest first
    logic       e_abort, e_irqh, e_irqs, e_bd;
    logic [4:0] e_code;
    logic [5:0] e_iph;
    logic [1:0] e_ips;

    function automatic logic [4:0] code_of(input logic [7:0] r);
        for (int i = 0; i < 8; i++)
            if (r[i]) return 5'(CODES[i]);
        return 5'd0;
    endfunction

    task automatic model_step();
        logic [5:0] seen, ph_;
        logic [1:0] ps_;
        bit         elig;
        if (!rst) begin
            m_ph = P_IDLE; m_armed = 0; m_hist = {};
            e_abort = 0; e_irqh = 0; e_irqs = 0; e_bd = 0;
            e_code = 0; e_iph = 0; e_ips = 0;
            return;
        end
        // value that has travelled through SYNC flops since reset
        seen = (m_hist.size() >= SYNC) ? m_hist[SYNC-1] : 6'd0;
        ph_  = seen & int_mask[7:2];
        ps_  = sw_int & int_mask[1:0];
        elig = int_enable && (ph_ != 0 || ps_ != 0);
        e_abort = 0; e_irqh = 0; e_irqs = 0;
        case (m_ph)
            P_IDLE:
                if (m_armed && (exc_req != 0 || elig)) begin
                    m_ph = P_ABORT;
                    if (exc_req != 0) begin
                        e_abort = 1;
                        e_code  = code_of(exc_req);
                    end else begin
                        e_code = 0;
                        e_irqh = (ph_ != 0);
                        e_irqs = (ps_ != 0);
                    end
                    e_bd = in_delay_slot; e_iph = ph_; e_ips = ps_;
                end
            P_ABORT:   m_ph = P_FLUSH;
            P_FLUSH:   if (flush_ack) m_ph = P_HANDLER;
            P_HANDLER: if (eret) m_ph = P_IDLE;
        endcase
        m_armed = 1;
        m_hist.push_front(hw_int);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
    endtask

    task automatic check_outputs();
        check_val("abort",     exception_abort, e_abort);
        check_val("code",      exception_code,  e_code);
        check_val("bd_p",      bd_p,            e_bd);
        check_val("irq_h",     irq_h,           e_irqh);
        check_val("irq_s",     irq_s,           e_irqs);
        check_val("ip_h",      ip_h,            e_iph);
        check_val("ip_s",      ip_s,            e_ips);
        check_val("flush_req", flush_req,       (m_ph == P_ABORT || m_ph == P_FLUSH));
        check_val("busy",      busy,            (m_ph != P_IDLE));
    endtask

    // Check what the previous edge produced, then apply the next inputs.
    task automatic tick(input logic r, input logic [7:0] er, input logic ds,
                        input logic [5:0] hw, input logic [1:0] sw, input logic [7:0] m,
                        input logic ie, input logic fa, input logic et);
        @(negedge clk);
        check_outputs();
        rst = r; exc_req = er; in_delay_slot = ds; hw_int = hw; sw_int = sw;
        int_mask = m; int_enable = ie; flush_ack = fa; eret = et;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 0);
    endtask

    int lat;

    initial begin
        rst = 0; exc_req = 0; in_delay_slot = 0; hw_int = 0; sw_int = 0;
        int_mask = 0; int_enable = 0; flush_ack = 0; eret = 0;
        model_step();
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Ov in delay slot, flush_ack three cycles later, then eret
        tick(1, 8'h04, 1, 0, 0, 8'hFF, 1, 0, 0);
        idle(1);
        check_val("ov_code", exception_code, 5'd12);
        check_val("ov_abort", exception_abort, 1'b1);
        check_val("ov_bd", bd_p, 1'b1);
        check_val("ov_flush", flush_req, 1'b1);
        idle(2);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 1, 0);
        idle(1);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 1);
        idle(1);
        check_val("ov_busy_end", busy, 1'b0);

        // RI beats Tr
        tick(1, 8'h82, 0, 0, 0, 8'hFF, 1, 0, 0);
        idle(1);
        check_val("ri_code", exception_code, 5'd10);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 1, 1);   // eret with flush_ack dropped
        idle(2);
        check_val("eret_drop_busy", busy, 1'b1);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 1);
        idle(1);

        // hw interrupt latency through the synchroniser
        tick(1, 0, 0, 6'b000100, 0, 8'hFF, 1, 0, 0);
        lat = 0;
        do begin
            tick(1, 0, 0, 6'b000100, 0, 8'hFF, 1, 0, 0);
            lat++;
        end while (!irq_h && lat < 10);
        check_val("irq_h_latency", lat, SYNC + 1);
        check_val("irq_h_iph", ip_h, 6'b000100);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 1, 0);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 1);
        idle(1);

        // Sys and sw_int together: Sys first, sw_int retaken after eret
        tick(1, 8'h08, 0, 0, 2'b01, 8'hFF, 1, 0, 0);
        tick(1, 0, 0, 0, 2'b01, 8'hFF, 1, 0, 0);
        check_val("sys_code", exception_code, 5'd8);
        check_val("sys_irq_s", irq_s, 1'b0);
        tick(1, 0, 0, 0, 2'b01, 8'hFF, 1, 1, 0);
        tick(1, 0, 0, 0, 2'b01, 8'hFF, 1, 0, 1);
        tick(1, 0, 0, 0, 2'b01, 8'hFF, 1, 0, 0);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 0);
        check_val("retake_irq_s", irq_s, 1'b1);
        check_val("retake_ip_s", ip_s, 2'b01);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 1, 0);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 1);

        // Interrupts disabled with everything pending
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 6'h3F, 0, 8'hFF, 0, 0, 0);
        check_val("disabled_busy", busy, 1'b0);
        tick(1, 0, 0, 6'h3F, 0, 8'hFF, 1, 0, 0);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 0);
        check_val("enabled_irq_h", irq_h, 1'b1);
        check_val("enabled_iph", ip_h, 6'h3F);

        // Reset during FLUSH, exc_req held across release
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 0);
        check_val("pre_rst_flush", flush_req, 1'b1);
        tick(0, 8'h10, 0, 0, 0, 8'hFF, 1, 0, 0);
        tick(1, 8'h10, 0, 0, 0, 8'hFF, 1, 0, 0);
        check_val("rst_flush_req", flush_req, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        tick(1, 8'h10, 0, 0, 0, 8'hFF, 1, 0, 0);
        check_val("rel_edge1_abort", exception_abort, 1'b0);
        tick(1, 0, 0, 0, 0, 8'hFF, 1, 0, 0);
        check_val("rel_edge2_abort", exception_abort, 1'b1);
        check_val("rel_edge2_code", exception_code, 5'd9);

        // Randomised traffic against the model
        begin
            logic [5:0] hw = 0;
            logic [7:0] m  = 8'hFF;
            for (int i = 0; i < 3000; i++) begin
                logic [7:0] er;
                if ($urandom_range(15) == 0) hw = 6'($urandom);
                if ($urandom_range(31) == 0) m  = 8'($urandom);
                er = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
                tick(($urandom_range(63) != 0), er, 1'($urandom), hw,
                     ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00, m,
                     ($urandom_range(3) != 0), ($urandom_range(2) == 0),
                     ($urandom_range(2) == 0));
            end
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/exc_arbiter.md
EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 Parameter: N_HW_INT, 6, number of hardware interrupt lines; fixed at 6 and matches cause IP[15:10].
REQ-002 Parameter: SYNC_STAGES, 2, flops in the hw_int synchroniser; legal values 2..3.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-low.
REQ-005 Port: exc_req  in  8  pipeline exception requests, level; bit 0 is highest priority.
REQ-006 Port: in_delay_slot  in  1  the faulting instruction sits in a branch delay slot.
REQ-007 Port: hw_int  in  6  raw asynchronous hardware interrupt lines.
REQ-008 Port: sw_int  in  2  software interrupt bits (Cause IP[9:8] as written by software).
REQ-009 Port: int_mask  in  8  Status IM[7:0]; bits 7:2 mask hw_int, bits 1:0 mask sw_int.
REQ-010 Port: int_enable  in  1  Status IE & ~EXL.
REQ-011 Port: flush_ack  in  1  pipeline has completed the flush.
REQ-012 Port: eret  in  1  ERET retired; single-cycle pulse.
REQ-013 Port: exception_abort  out  1  one-cycle pulse; a synchronous exception was taken.
REQ-014 Port: exception_code  out  5  ExcCode of the taken event.
REQ-015 Port: bd_p  out  1  delay-slot flag of the taken event.
REQ-016 Port: irq_h, irq_s  out  1 each  one-cycle pulses; hardware/software interrupt taken.
REQ-017 Port: ip_h  out  6; ip_s  out  2  snapshot of the pending, masked interrupt bits.
REQ-018 Port: flush_req  out  1  level; asks the pipeline to flush.
REQ-019 Port: busy  out  1  high in every state except IDLE.

Function
REQ-020 exc_req priority and ExcCode mapping, bit 0 to bit 7: AdEL-fetch=4, RI=10, Ov=12, Sys=8, Bp=9, AdEL-load=4, AdES=5, Tr=13.
REQ-021 hw_int passes through SYNC_STAGES flops; pend_h = sync_hw & int_mask[7:2]; pend_s = sw_int & int_mask[1:0].
REQ-022 An interrupt is eligible only when int_enable=1 and (pend_h | pend_s) != 0.
REQ-023 FSM has four states: IDLE, ABORT, FLUSH, HANDLER.
REQ-024 IDLE -> ABORT when exc_req != 0 or an interrupt is eligible; otherwise remain in IDLE.
REQ-025 ABORT lasts exactly one cycle, then goes to FLUSH.
REQ-026 FLUSH -> HANDLER on the first cycle flush_ack=1; otherwise remain in FLUSH, with no timeout.
REQ-027 HANDLER -> IDLE when eret=1; otherwise remain in HANDLER.
REQ-028 Latency: an event sampled in IDLE at cycle N produces its outputs registered at N+1, in the ABORT cycle.
REQ-029 When exc_req != 0 and an interrupt is eligible in the same cycle, the exception wins; the interrupt stays pending, is not lost, and is retaken after eret.
REQ-030 Exception taken: exception_abort=1, exception_code from the REQ-020 encoder, bd_p=in_delay_slot, irq_h=irq_s=0.
REQ-031 Interrupt taken: exception_abort=0, exception_code=0, irq_h=|pend_h, irq_s=|pend_s, ip_h=pend_h, ip_s=pend_s, bd_p=in_delay_slot.
REQ-032 The exception_abort, irq_h and irq_s pulses are high only in the ABORT cycle.
REQ-033 exception_code, bd_p, ip_h and ip_s hold their values until the next ABORT.
REQ-034 flush_req is high in ABORT and FLUSH and low elsewhere.
REQ-035 flush_ack is ignored outside FLUSH.
REQ-036 eret is ignored outside HANDLER.
REQ-037 exc_req and interrupts arriving outside IDLE are ignored and not queued; level interrupts are re-evaluated on return to IDLE.
REQ-038 flush_ack and eret asserted in the same cycle while in FLUSH: take FLUSH -> HANDLER only; that eret is dropped.

Reset
REQ-039 With rst=0 at a clock edge: FSM=IDLE, synchroniser flops=0, and every output=0.
REQ-040 Reset asserted in any state, including FLUSH with flush_req high, aborts the sequence; flush_req drops on the next edge.
REQ-041 No event is taken in the first cycle after reset release; sampling starts in IDLE on the following edge.

Structure
REQ-042 ExcCode constants, FSM state encoding and the exc_req bit assignments live in the shared header alongside `ZERO/`UNKNOW.
REQ-043 The block has one sub-module, int_sync (parameterised SYNC_STAGES x 6-bit synchroniser), built from flopr instances; all other registers use flopr/flopren.
REQ-044 Outputs feed the cause unit directly: exception_abort, exception_code, bd_p, irq_h, irq_s, ip_h, ip_s.

Verification
REQ-045 exc_req=8'b0000_0100, in_delay_slot=1 -> next cycle exception_abort=1, code=12, bd_p=1, flush_req=1; flush_ack 3 cycles later -> HANDLER; eret -> IDLE, busy=0.
REQ-046 exc_req=8'b1000_0010 -> code=10 (RI wins over Tr).
REQ-047 hw_int=6'b000100, int_mask=8'hFF, int_enable=1 -> irq_h pulses SYNC_STAGES+1 cycles after the input edge, ip_h=6'b000100, code=0, exception_abort=0.
REQ-048 exc_req bit 3 and sw_int=2'b01 (unmasked, enabled) in the same cycle -> code=8, irq_s=0; after eret, irq_s=1 with ip_s=2'b01.
REQ-049 int_enable=0 with pending hw_int=6'h3F -> no event for 20 cycles; int_enable raised -> irq_h next eligible cycle+1.
REQ-050 rst=0 during FLUSH -> next edge: all outputs 0, busy=0; an exc_req held through reset release is taken on the second edge after release.
